// File: rtl/mem_writeback_if.sv
// ----------------------------------------------------------------------------
// mem_writeback_if
//   Data-memory request/acknowledge bus between the memory/writeback stage
//   (master) and the data memory (slave).
//   dmem_req    master -> slave  request, held until ack or abort
//   dmem_we     master -> slave  1 = store, 0 = load; valid while dmem_req
//   dmem_addr   master -> slave  access address
//   dmem_wdata  master -> slave  store data
//   dmem_rdata  slave -> master  load data, sampled with dmem_ack
//   dmem_ack    slave -> master  one-cycle completion strobe
// ----------------------------------------------------------------------------
interface mem_writeback_if #(
    parameter int ADDR_WIDTH = 22
) ();
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [31:0]           dmem_wdata;
    logic [31:0]           dmem_rdata;
    logic                  dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_writeback.sv
// ----------------------------------------------------------------------------
// mem_writeback
//   Memory/writeback stage. Takes one op at a time from execute, performs the
//   data-memory access for loads/stores, then drives the register-file and
//   CPSR write ports for a single cycle and counts retired ops.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   ex_valid / ex_ready   op handshake with execute (ready only in IDLE)
//   result_in, cpsr_in    ALU result and compare flags
//   rd_num_in, rd_val_in  destination/source register and store data
//   md_in                 memory address (low ADDR_WIDTH bits used)
//   is_*_op               op class flags (ld > str > cmp > alu)
//   dmem                  data-memory request/ack bus (master side)
//   wb_rd_*               register-file write port
//   wb_cpsr_*             CPSR write port
//   mem_err               sticky access-timeout flag
//   retire_count          ops retired through WRITEBACK (wrapping)
// ----------------------------------------------------------------------------
module mem_writeback #(
    parameter int ADDR_WIDTH = 22,
    parameter int TIMEOUT    = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [31:0]            result_in,
    input  logic [31:0]            cpsr_in,
    input  logic [3:0]             rd_num_in,
    input  logic [31:0]            rd_val_in,
    input  logic [31:0]            md_in,
    input  logic                   is_alu_op,
    input  logic                   is_cmp_op,
    input  logic                   is_ld_op,
    input  logic                   is_str_op,
    mem_writeback_if.master        dmem,
    output logic [3:0]             wb_rd_num,
    output logic                   wb_rd_write_en,
    output logic [31:0]            wb_rd_in,
    output logic                   wb_cpsr_write_en,
    output logic [31:0]            wb_cpsr_in,
    output logic                   mem_err,
    output logic [31:0]            retire_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WB     = 2'd2
    } state_t;

    // Last wait-counter value before the access is abandoned.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic                  ex_ready_q, ex_ready_d;
    logic                  op_ld_q, op_ld_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic                  dmem_req_q, dmem_req_d;
    logic                  dmem_we_q, dmem_we_d;
    logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]           dmem_wdata_q, dmem_wdata_d;
    logic [3:0]            wb_rd_num_q, wb_rd_num_d;
    logic                  wb_rd_write_en_q, wb_rd_write_en_d;
    logic [31:0]           wb_rd_in_q, wb_rd_in_d;
    logic                  wb_cpsr_write_en_q, wb_cpsr_write_en_d;
    logic [31:0]           wb_cpsr_in_q, wb_cpsr_in_d;
    logic                  mem_err_q, mem_err_d;
    logic [31:0]           retire_count_q, retire_count_d;

    // Address bits above ADDR_WIDTH are intentionally dropped.
    generate
        if (ADDR_WIDTH < 32) begin : g_addr_hi
            logic unused_md_hi;
            assign unused_md_hi = ^md_in[31:ADDR_WIDTH];
        end
    endgenerate

    always_comb begin
        state_d            = state_q;
        ex_ready_d         = ex_ready_q;
        op_ld_d            = op_ld_q;
        wait_cnt_d         = wait_cnt_q;
        dmem_req_d         = dmem_req_q;
        dmem_we_d          = dmem_we_q;
        dmem_addr_d        = dmem_addr_q;
        dmem_wdata_d       = dmem_wdata_q;
        wb_rd_num_d        = wb_rd_num_q;
        wb_rd_in_d         = wb_rd_in_q;
        wb_cpsr_in_d       = wb_cpsr_in_q;
        mem_err_d          = mem_err_q;
        retire_count_d     = retire_count_q;
        // Write enables are single-cycle strobes, asserted only on the
        // transition into WRITEBACK.
        wb_rd_write_en_d   = 1'b0;
        wb_cpsr_write_en_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (is_ld_op || is_str_op) begin
                        state_d      = S_ACCESS;
                        ex_ready_d   = 1'b0;
                        op_ld_d      = is_ld_op;
                        wait_cnt_d   = 8'd0;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = ~is_ld_op;
                        dmem_addr_d  = md_in[ADDR_WIDTH-1:0];
                        dmem_wdata_d = rd_val_in;
                        wb_rd_num_d  = rd_num_in;
                        wb_cpsr_in_d = cpsr_in;
                        // Load data replaces wb_rd_in only when it arrives.
                        if (!is_ld_op) begin
                            wb_rd_in_d = result_in;
                        end
                    end else if (is_cmp_op || is_alu_op) begin
                        state_d            = S_WB;
                        ex_ready_d         = 1'b0;
                        op_ld_d            = 1'b0;
                        wb_rd_num_d        = rd_num_in;
                        wb_rd_in_d         = result_in;
                        wb_cpsr_in_d       = cpsr_in;
                        wb_cpsr_write_en_d = is_cmp_op;
                        wb_rd_write_en_d   = ~is_cmp_op;
                        retire_count_d     = retire_count_q + 32'd1;
                    end
                    // No class flag: op is consumed without any effect.
                end
            end

            S_ACCESS: begin
                if (dmem.dmem_ack) begin
                    state_d          = S_WB;
                    dmem_req_d       = 1'b0;
                    wb_rd_write_en_d = op_ld_q;
                    retire_count_d   = retire_count_q + 32'd1;
                    if (op_ld_q) begin
                        wb_rd_in_d = dmem.dmem_rdata;
                    end
                end else if (wait_cnt_q == LAST_WAIT) begin
                    // Abort: retire without any register write.
                    state_d        = S_WB;
                    dmem_req_d     = 1'b0;
                    mem_err_d      = 1'b1;
                    retire_count_d = retire_count_q + 32'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            S_WB: begin
                state_d    = S_IDLE;
                ex_ready_d = 1'b1;
            end

            default: begin
                state_d    = S_IDLE;
                ex_ready_d = 1'b1;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= S_IDLE;
            ex_ready_q         <= 1'b1;
            op_ld_q            <= 1'b0;
            wait_cnt_q         <= 8'd0;
            dmem_req_q         <= 1'b0;
            dmem_we_q          <= 1'b0;
            dmem_addr_q        <= '0;
            dmem_wdata_q       <= 32'd0;
            wb_rd_num_q        <= 4'd0;
            wb_rd_write_en_q   <= 1'b0;
            wb_rd_in_q         <= 32'd0;
            wb_cpsr_write_en_q <= 1'b0;
            wb_cpsr_in_q       <= 32'd0;
            mem_err_q          <= 1'b0;
            retire_count_q     <= 32'd0;
        end else begin
            state_q            <= state_d;
            ex_ready_q         <= ex_ready_d;
            op_ld_q            <= op_ld_d;
            wait_cnt_q         <= wait_cnt_d;
            dmem_req_q         <= dmem_req_d;
            dmem_we_q          <= dmem_we_d;
            dmem_addr_q        <= dmem_addr_d;
            dmem_wdata_q       <= dmem_wdata_d;
            wb_rd_num_q        <= wb_rd_num_d;
            wb_rd_write_en_q   <= wb_rd_write_en_d;
            wb_rd_in_q         <= wb_rd_in_d;
            wb_cpsr_write_en_q <= wb_cpsr_write_en_d;
            wb_cpsr_in_q       <= wb_cpsr_in_d;
            mem_err_q          <= mem_err_d;
            retire_count_q     <= retire_count_d;
        end
    end

    assign ex_ready         = ex_ready_q;
    assign dmem.dmem_req    = dmem_req_q;
    assign dmem.dmem_we     = dmem_we_q;
    assign dmem.dmem_addr   = dmem_addr_q;
    assign dmem.dmem_wdata  = dmem_wdata_q;
    assign wb_rd_num        = wb_rd_num_q;
    assign wb_rd_write_en   = wb_rd_write_en_q;
    assign wb_rd_in         = wb_rd_in_q;
    assign wb_cpsr_write_en = wb_cpsr_write_en_q;
    assign wb_cpsr_in       = wb_cpsr_in_q;
    assign mem_err          = mem_err_q;
    assign retire_count     = retire_count_q;

endmodule

// File: tb/tb_mem_writeback.sv
// ----------------------------------------------------------------------------
// tb_mem_writeback
//   Scoreboard bench for mem_writeback. The driver issues directed and random
//   ops, predicts each op's memory request and writeback outcome and queues
//   them; a memory responder and a writeback monitor pop and compare.
// ----------------------------------------------------------------------------
module tb_mem_writeback;

    localparam int ADDR_WIDTH = 22;
    localparam int TIMEOUT    = 15;
    localparam int NEVER      = 99;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] result_in, cpsr_in, rd_val_in, md_in;
    logic [3:0]  rd_num_in;
    logic        is_alu_op, is_cmp_op, is_ld_op, is_str_op;
    logic [3:0]  wb_rd_num;
    logic        wb_rd_write_en, wb_cpsr_write_en, mem_err;
    logic [31:0] wb_rd_in, wb_cpsr_in, retire_count;

    mem_writeback_if #(.ADDR_WIDTH(ADDR_WIDTH)) dmem_bus ();

    logic        resp_ack = 1'b0;
    logic        late_ack = 1'b0;
    logic [31:0] resp_rdata = 32'd0;
    assign dmem_bus.dmem_ack   = resp_ack | late_ack;
    assign dmem_bus.dmem_rdata = resp_rdata;

    mem_writeback #(.ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .result_in        (result_in),
        .cpsr_in          (cpsr_in),
        .rd_num_in        (rd_num_in),
        .rd_val_in        (rd_val_in),
        .md_in            (md_in),
        .is_alu_op        (is_alu_op),
        .is_cmp_op        (is_cmp_op),
        .is_ld_op         (is_ld_op),
        .is_str_op        (is_str_op),
        .dmem             (dmem_bus),
        .wb_rd_num        (wb_rd_num),
        .wb_rd_write_en   (wb_rd_write_en),
        .wb_rd_in         (wb_rd_in),
        .wb_cpsr_write_en (wb_cpsr_write_en),
        .wb_cpsr_in       (wb_cpsr_in),
        .mem_err          (mem_err),
        .retire_count     (retire_count)
    );

    typedef struct {
        bit          rd_en;
        bit          cpsr_en;
        logic [3:0]  rd_num;
        logic [31:0] rd_val;
        logic [31:0] cpsr_val;
        bit          err;
        logic [31:0] retire;
    } wb_exp_t;

    typedef struct {
        bit                    we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
        int                    ack_at;
        logic [31:0]           rdata;
        int                    len;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];

    int          checks = 0;
    int          errors = 0;
    bit          mdl_err = 1'b0;
    logic [31:0] mdl_retire = 32'd0;
    bit          mem_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ------------------------------------------------------------------
    // Memory responder: checks each request and acks at the planned cycle.
    // ------------------------------------------------------------------
    req_exp_t cur_req;
    int       req_cyc  = 0;
    bit       prev_req = 1'b0;

    always @(negedge clk) begin
        if (!mem_en) begin
            resp_ack = 1'b0;
            prev_req = 1'b0;
        end else begin
            resp_ack = 1'b0;
            if (dmem_bus.dmem_req) begin
                if (!prev_req) begin
                    if (req_q.size() == 0) begin
                        fail_now("unexpected_req");
                        cur_req = '{default: 0};
                        cur_req.ack_at = 0;
                    end else begin
                        cur_req = req_q.pop_front();
                    end
                    req_cyc = 0;
                    chk("req_we", 32'(dmem_bus.dmem_we), 32'(cur_req.we));
                    chk("req_addr", 32'(dmem_bus.dmem_addr), 32'(cur_req.addr));
                    if (cur_req.we) chk("req_wdata", dmem_bus.dmem_wdata, cur_req.wdata);
                end else begin
                    chk("hold_we", 32'(dmem_bus.dmem_we), 32'(cur_req.we));
                    chk("hold_addr", 32'(dmem_bus.dmem_addr), 32'(cur_req.addr));
                    if (cur_req.we) chk("hold_wdata", dmem_bus.dmem_wdata, cur_req.wdata);
                end
                if (req_cyc == cur_req.ack_at) begin
                    resp_ack   = 1'b1;
                    resp_rdata = cur_req.rdata;
                end else begin
                    resp_rdata = $urandom;
                end
                req_cyc++;
            end else begin
                if (prev_req) chk("req_len", 32'(req_cyc), 32'(cur_req.len));
                // Acks with no request outstanding must be ignored.
                if ($urandom_range(0, 5) == 0) resp_ack = 1'b1;
                resp_rdata = $urandom;
            end
            prev_req = dmem_bus.dmem_req;
        end
    end

    // ------------------------------------------------------------------
    // Writeback monitor: every retire_count step is one WRITEBACK cycle.
    // ------------------------------------------------------------------
    logic [31:0] last_retire = 32'd0;
    bit          prev_wb = 1'b0;
    wb_exp_t     got;

    always @(negedge clk) begin
        if (reset) begin
            last_retire = 32'd0;
            prev_wb     = 1'b0;
        end else begin
            if (prev_wb) chk("ready_after_wb", 32'(ex_ready), 32'd1);
            prev_wb = 1'b0;
            if (retire_count !== last_retire) begin
                if (wb_q.size() == 0) begin
                    fail_now("unexpected_retire");
                end else begin
                    got = wb_q.pop_front();
                    chk("wb_rd_en", 32'(wb_rd_write_en), 32'(got.rd_en));
                    chk("wb_cpsr_en", 32'(wb_cpsr_write_en), 32'(got.cpsr_en));
                    if (got.rd_en) begin
                        chk("wb_rd_num", 32'(wb_rd_num), 32'(got.rd_num));
                        chk("wb_rd_in", wb_rd_in, got.rd_val);
                    end
                    if (got.cpsr_en) chk("wb_cpsr_in", wb_cpsr_in, got.cpsr_val);
                    chk("mem_err", 32'(mem_err), 32'(got.err));
                    chk("retire_count", retire_count, got.retire);
                    chk("ready_in_wb", 32'(ex_ready), 32'd0);
                end
                last_retire = retire_count;
                prev_wb     = 1'b1;
            end else if (wb_rd_write_en || wb_cpsr_write_en) begin
                fail_now("stray_strobe");
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver with reference model. delay >= TIMEOUT means no ack at all.
    // ------------------------------------------------------------------
    task automatic issue(input bit ld, input bit str, input bit cmp, input bit alu,
                         input logic [3:0] rd, input logic [31:0] res, input logic [31:0] cpsr,
                         input logic [31:0] rdv, input logic [31:0] md,
                         input int delay, input logic [31:0] rdata);
        wb_exp_t  w;
        req_exp_t r;
        bit       acked;
        int       guard;
        guard = 0;
        @(negedge clk);
        while (ex_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            fail_now("ready_timeout");
            return;
        end
        acked = (delay < TIMEOUT);
        w = '{default: 0};
        if (ld || str) begin
            r.we     = !ld;
            r.addr   = md[ADDR_WIDTH-1:0];
            r.wdata  = rdv;
            r.ack_at = acked ? delay : -1;
            r.rdata  = rdata;
            r.len    = acked ? delay + 1 : TIMEOUT;
            req_q.push_back(r);
            if (!acked) mdl_err = 1'b1;
            w.rd_en  = ld && acked;
            w.rd_num = rd;
            w.rd_val = rdata;
        end else if (cmp) begin
            w.cpsr_en  = 1'b1;
            w.cpsr_val = cpsr;
        end else if (alu) begin
            w.rd_en  = 1'b1;
            w.rd_num = rd;
            w.rd_val = res;
        end
        if (ld || str || cmp || alu) begin
            mdl_retire = mdl_retire + 32'd1;
            w.retire   = mdl_retire;
            w.err      = mdl_err;
            wb_q.push_back(w);
        end
        is_ld_op  = ld;
        is_str_op = str;
        is_cmp_op = cmp;
        is_alu_op = alu;
        rd_num_in = rd;
        result_in = res;
        cpsr_in   = cpsr;
        rd_val_in = rdv;
        md_in     = md;
        ex_valid  = 1'b1;
        @(posedge clk);
        #1;
        ex_valid  = 1'b0;
        {is_ld_op, is_str_op, is_cmp_op, is_alu_op} = 4'($urandom);
        result_in = $urandom;
        md_in     = $urandom;
        if (!(ld || str) && (cmp || alu)) begin
            @(negedge clk);
            chk("alu_cmp_latency", 32'(wb_rd_write_en | wb_cpsr_write_en), 32'd1);
        end else if (!(ld || str || cmp || alu)) begin
            @(negedge clk);
            chk("nop_ready", 32'(ex_ready), 32'd1);
            chk("nop_no_req", 32'(dmem_bus.dmem_req), 32'd0);
        end
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        ex_valid = 1'b0;
        {is_ld_op, is_str_op, is_cmp_op, is_alu_op} = 4'd0;
        result_in = 32'd0; cpsr_in = 32'd0; rd_val_in = 32'd0; md_in = 32'd0; rd_num_in = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_bus.dmem_we), 32'd0);
        chk("rst_addr", 32'(dmem_bus.dmem_addr), 32'd0);
        chk("rst_wb_rd_en", 32'(wb_rd_write_en), 32'd0);
        chk("rst_wb_cpsr_en", 32'(wb_cpsr_write_en), 32'd0);
        chk("rst_wb_rd_in", wb_rd_in, 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_retire", retire_count, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        mem_en = 1'b1;

        // Directed scenarios.
        issue(0, 0, 0, 1, 4'd1, 32'h1234, 32'd0, 32'd0, 32'd0, 0, 32'd0);
        issue(0, 0, 1, 0, 4'd2, 32'h0, 32'h4000_0000, 32'd0, 32'd0, 0, 32'd0);
        issue(1, 0, 0, 0, 4'd8, 32'h0, 32'd0, 32'd0, 32'd9, 2, 32'hDEAD_BEEF);
        issue(0, 1, 0, 0, 4'd3, 32'h0, 32'd0, 32'hA5A5, 32'd11, 0, 32'd0);
        issue(0, 0, 0, 0, 4'd4, 32'h77, 32'd0, 32'd0, 32'd0, 0, 32'd0);
        issue(1, 0, 0, 0, 4'd5, 32'h0, 32'd0, 32'd0, 32'h0040_0010, NEVER, 32'd0);
        issue(1, 1, 1, 1, 4'd6, 32'h5, 32'd1, 32'h9, 32'hFFFF_FFFF, TIMEOUT - 1, 32'h0BAD_F00D);
        issue(0, 1, 1, 1, 4'd7, 32'h5, 32'd1, 32'h9, 32'h20, TIMEOUT, 32'd0);
        issue(0, 0, 1, 1, 4'd9, 32'h6, 32'h8000_0000, 32'd0, 32'd0, 0, 32'd0);

        // Random ops with mixed flags to exercise class priority.
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                  4'($urandom), $urandom, $urandom, $urandom, $urandom,
                  $urandom_range(0, TIMEOUT + 2), $urandom);
        end

        guard = 0;
        while ((wb_q.size() != 0 || req_q.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_wb_q", 32'(wb_q.size()), 32'd0);
        chk("drain_req_q", 32'(req_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        // Reset during the second ACCESS cycle of a load; a late ack follows.
        mem_en = 1'b0;
        @(negedge clk);
        is_ld_op = 1'b1; is_str_op = 1'b0; is_cmp_op = 1'b0; is_alu_op = 1'b0;
        rd_num_in = 4'd10; md_in = 32'h55;
        ex_valid = 1'b1;
        @(posedge clk);
        #1 ex_valid = 1'b0;
        is_ld_op = 1'b0;
        @(negedge clk);
        chk("rst6_req_c1", 32'(dmem_bus.dmem_req), 32'd1);
        chk("rst6_mem_err_before", 32'(mem_err), 32'(mdl_err));
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst6_req_c2", 32'(dmem_bus.dmem_req), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst6_req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("rst6_ready", 32'(ex_ready), 32'd1);
        chk("rst6_mem_err", 32'(mem_err), 32'd0);
        chk("rst6_retire", retire_count, 32'd0);
        chk("rst6_rd_en", 32'(wb_rd_write_en), 32'd0);
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        chk("late_ack_req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("late_ack_rd_en", 32'(wb_rd_write_en), 32'd0);
        chk("late_ack_retire", retire_count, 32'd0);
        chk("late_ack_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        chk("late_ack_retire2", retire_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

endmodule
